reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
// - Source end of the reset path: generates the staged per-domain active-low resets that downstream
//   reset_sync-style synchronizers or same-clock logic consume.
// - Holds all domains in reset for a minimum pulse width after POR or a soft request.
// - Then releases domains one at a time, domain 0 first, with a fixed stagger, and reports completion.
// - Single clock; sits at the top of each clock domain's reset tree.
// PARAMETERS
// - N_DOMAINS       4   number of reset outputs (>=1)
// - ASSERT_CYCLES  16   min cycles all outputs held low before release starts (>=1)
// - STAGGER_CYCLES  8   cycles between successive domain releases (>=1)
// - CW  derived: $clog2(max(ASSERT_CYCLES,STAGGER_CYCLES)+1)
// PORTS
// - i_clk       in   1          clock
// - i_rst_n     in   1          reset, synchronous, active-low
// - i_req       in   1          soft reset request, sampled each edge (level or pulse)
// - i_hold      in   1          extend HOLD while high
// - o_rst_n     out  N_DOMAINS  per-domain reset, active-low, registered
// - o_busy      out  1          high while not IDLE, registered
// - o_done      out  1          1-cycle pulse when last domain released
// BEHAVIOUR
// - Reset is synchronous, active-low: any edge with i_rst_n=0 forces:
//   state=HOLD, cnt=0, idx=0, o_rst_n='0, o_busy=1, o_done=0.
// - POR therefore runs a full sequence automatically.
// - FSM states: IDLE, HOLD, RELEASE.
// - HOLD: o_rst_n all 0.
//   - If i_hold=1: cnt saturates at ASSERT_CYCLES-1.
//   - Else cnt++; at cnt==ASSERT_CYCLES-1 -> RELEASE, cnt=0, idx=0.
// - RELEASE: cnt++ each edge.
//   - At cnt==STAGGER_CYCLES-1: o_rst_n[idx]<=1, cnt=0, idx++.
//   - Releasing idx==N_DOMAINS-1 -> IDLE, o_busy<=0, o_done<=1 on that same edge.
// - IDLE: outputs stable, o_done=0.
// - Release timing: with the first post-reset edge counted as 1, domain k goes high on edge
//   ASSERT_CYCLES+(k+1)*STAGGER_CYCLES.
// - Released domains never re-assert except via HOLD entry.
// - i_req=1:
//   - In IDLE or RELEASE: next edge -> HOLD, o_rst_n='0 for all domains at once, cnt=0, o_busy=1.
//   - In HOLD: cnt=0 (restart the min pulse).
//   - Priority: i_rst_n > i_req > counting.
// - i_req on the edge that would release the last domain: i_req wins -> HOLD, no o_done.
// - i_hold is ignored outside HOLD.
// - o_done is never high in consecutive cycles.
// - N_DOMAINS=1: single release, done on the same edge.
// - Counters are unsigned CW bits; compares are exact equality; no wrap is reachable.
// STRUCTURE
// - reset_seq_pkg: typedef enum logic [1:0] {IDLE, HOLD, RELEASE} rs_state_t.
// - No sub-module: the FSM, cnt, idx (width $clog2(N_DOMAINS) or 1) and the o_rst_n register
//   are all inline.
// - Elaboration-time assertions: N_DOMAINS>=1, ASSERT_CYCLES>=1, STAGGER_CYCLES>=1.
// TESTING (N_DOMAINS=3, ASSERT_CYCLES=4, STAGGER_CYCLES=2 unless stated)
// - POR: i_rst_n low 3 cycles then high.
//   -> o_rst_n=000 for edges 1-5; 001 at edge 6, 011 at edge 8, 111 at edge 10.
//   -> o_done=1 for exactly the cycle after edge 10; o_busy falls at edge 10.
// - Soft request in IDLE: 1-cycle i_req.
//   -> o_rst_n=000 next edge; same release timeline as POR relative to that edge.
// - i_req during RELEASE with o_rst_n=001.
//   -> all return to 000 next edge; the full ASSERT_CYCLES hold is re-run; no o_done until the
//      new sequence completes.
// - i_hold=1 for 10 cycles from entry to HOLD.
//   -> o_rst_n stays 000 throughout; release of domain 0 occurs STAGGER_CYCLES edges after
//      RELEASE entry, which follows i_hold falling.
// - i_req coincident with the edge releasing domain 2.
//   -> o_rst_n=000, o_done stays 0, o_busy stays 1.
// - i_rst_n low mid-RELEASE (o_rst_n=011).
//   -> 000 on that edge; the sequence restarts cleanly after deassert.
// - N_DOMAINS=1, ASSERT_CYCLES=1, STAGGER_CYCLES=1.
//   -> release at edge 2 after reset; o_done pulses once.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and sizing helper for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, RELEASE} rs_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all domains in reset for a minimum pulse, then releases them
// one by one with a fixed stagger and pulses o_done when the last domain is released.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_DOMAINS      = 4,
    parameter int ASSERT_CYCLES  = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    input  logic                 i_hold,
    output logic [N_DOMAINS-1:0] o_rst_n,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int CW = $clog2(max2(ASSERT_CYCLES, STAGGER_CYCLES) + 1);
    localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    if (N_DOMAINS < 1) begin : g_bad_n
        $error("N_DOMAINS must be >= 1");
    end
    if (ASSERT_CYCLES < 1) begin : g_bad_assert
        $error("ASSERT_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger
        $error("STAGGER_CYCLES must be >= 1");
    end

    rs_state_t            state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic [N_DOMAINS-1:0] rst_nxt;
    logic                 busy_nxt, done_nxt;
    logic                 hold_hit, stag_hit, last, rel;

    assign hold_hit = cnt == CW'(ASSERT_CYCLES - 1);
    assign stag_hit = cnt == CW'(STAGGER_CYCLES - 1);
    assign last     = idx == IW'(N_DOMAINS - 1);
    // a request always beats a pending release, so the last domain cannot be let go under it
    assign rel      = (state == RELEASE) && stag_hit && !i_req;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= HOLD;
            cnt     <= '0;
            idx     <= '0;
            o_rst_n <= '0;
            o_busy  <= 1'b1;
            o_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            o_rst_n <= rst_nxt;
            o_busy  <= busy_nxt;
            o_done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (i_req) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else if (state == HOLD) begin
            if (i_hold) begin
                cnt_nxt = hold_hit ? cnt : cnt + CW'(1);
            end else if (hold_hit) begin
                state_nxt = RELEASE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end else if (state == RELEASE) begin
            if (stag_hit) begin
                state_nxt = last ? IDLE : RELEASE;
                cnt_nxt   = '0;
                idx_nxt   = last ? '0 : idx + IW'(1);
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_comb begin
        rst_nxt  = (state_nxt == HOLD) ? '0
                 : rel ? (o_rst_n | (N_DOMAINS'(1) << idx))
                 : o_rst_n;
        busy_nxt = state_nxt != IDLE;
        done_nxt = rel && last;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of the staged reset timeline, soft requests, hold,
// mid-sequence reset, and a single-domain minimal configuration.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, req, hold;
    logic [2:0] rst_out;
    logic       busy, done;

    logic       rst1_n, req1, hold1;
    logic [0:0] rst1_out;
    logic       busy1, done1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.N_DOMAINS(3), .ASSERT_CYCLES(4), .STAGGER_CYCLES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_hold(hold),
        .o_rst_n(rst_out), .o_busy(busy), .o_done(done)
    );

    reset_sequencer #(.N_DOMAINS(1), .ASSERT_CYCLES(1), .STAGGER_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst1_n), .i_req(req1), .i_hold(hold1),
        .o_rst_n(rst1_out), .o_busy(busy1), .o_done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] r, input logic b, input logic d);
        chk({tag, ".rst"}, rst_out, r);
        chk({tag, ".busy"}, 3'(busy), 3'(b));
        chk({tag, ".done"}, 3'(done), 3'(d));
    endtask

    // Edge e after HOLD entry: domain k rises at 4+(k+1)*2 -> edges 6, 8, 10.
    task automatic run_seq(input string tag);
        for (int e = 1; e <= 11; e++) begin
            tick();
            chk_all($sformatf("%s.e%0d", tag, e), {e >= 10, e >= 8, e >= 6}, e < 10, e == 10);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; hold = 1'b0;
        rst1_n = 1'b0; req1 = 1'b0; hold1 = 1'b0;
        tick(); tick(); tick();
        chk_all("por_reset", 3'b000, 1'b1, 1'b0);
        rst_n = 1'b1;
        run_seq("por");
        tick();
        chk_all("idle_stable", 3'b111, 1'b0, 1'b0);

        req = 1'b1;
        tick();
        chk_all("soft_req_entry", 3'b000, 1'b1, 1'b0);
        req = 1'b0;
        run_seq("soft");

        req = 1'b1; tick(); req = 1'b0;
        repeat (6) tick();
        chk_all("rel_mid_001", 3'b001, 1'b1, 1'b0);
        req = 1'b1;
        tick();
        chk_all("rel_req_abort", 3'b000, 1'b1, 1'b0);
        req = 1'b0;
        run_seq("rerun");

        req = 1'b1; tick(); req = 1'b0;
        hold = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_all($sformatf("hold.c%0d", i), 3'b000, 1'b1, 1'b0);
        end
        hold = 1'b0;
        tick();
        chk_all("hold_rel_entry", 3'b000, 1'b1, 1'b0);
        tick();
        chk_all("hold_rel_wait", 3'b000, 1'b1, 1'b0);
        tick();
        chk_all("hold_rel_d0", 3'b001, 1'b1, 1'b0);
        repeat (4) tick();
        chk_all("hold_rel_done", 3'b111, 1'b0, 1'b1);
        tick();
        chk_all("hold_done_once", 3'b111, 1'b0, 1'b0);

        req = 1'b1; tick(); req = 1'b0;
        repeat (9) tick();
        chk_all("pre_last_011", 3'b011, 1'b1, 1'b0);
        req = 1'b1;
        tick();
        chk_all("req_at_last", 3'b000, 1'b1, 1'b0);
        req = 1'b0;
        run_seq("after_last_req");

        req = 1'b1; tick(); req = 1'b0;
        repeat (8) tick();
        chk_all("pre_rst_011", 3'b011, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_all("mid_rst", 3'b000, 1'b1, 1'b0);
        rst_n = 1'b1;
        run_seq("post_rst");

        tick();
        chk("n1.reset.rst", 3'(rst1_out), 3'b000);
        chk("n1.reset.busy", 3'(busy1), 3'b001);
        rst1_n = 1'b1;
        tick();
        chk("n1.e1.rst", 3'(rst1_out), 3'b000);
        chk("n1.e1.done", 3'(done1), 3'b000);
        tick();
        chk("n1.e2.rst", 3'(rst1_out), 3'b001);
        chk("n1.e2.done", 3'(done1), 3'b001);
        chk("n1.e2.busy", 3'(busy1), 3'b000);
        tick();
        chk("n1.e3.done", 3'(done1), 3'b000);
        chk("n1.e3.rst", 3'(rst1_out), 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
